rx_hold_fifo_buf: RTL

// - Receive-side hold buffer between the XGMII RX decoder (writer) and the RX enqueue logic (reader).
// - Stores 72-bit entries of {8-bit status, 64-bit data} in one clock domain, with a show-ahead registered output.
// - Provides full/almost-full back-pressure to the decoder and empty/almost-empty flags to the enqueue logic.
// - Counts words dropped on overflow, with a saturating counter.

---
 rtl/rx_hold_fifo_buf_pkg.sv | 17 +
 rtl/rx_hold_fifo_mem.sv | 36 +++
 rtl/rx_hold_fifo_buf.sv | 126 ++++++++++++
 3 files changed

// File: rtl/rx_hold_fifo_buf_pkg.sv
// rx_hold_fifo_buf_pkg
// Shared constants and the entry layout for the RX hold FIFO.
// RX_HOLD_FIFO_AWIDTH is the default memory address width; the memory holds
// 2**RX_HOLD_FIFO_AWIDTH entries. Each entry is {8-bit status, 64-bit data}.
package rx_hold_fifo_buf_pkg;

    localparam int RX_HOLD_FIFO_AWIDTH = 3;
    localparam int RX_DATA_W           = 64;
    localparam int RX_STAT_W           = 8;
    localparam int RX_ENTRY_W          = RX_STAT_W + RX_DATA_W;

    typedef struct packed {
        logic [RX_STAT_W-1:0] status;
        logic [RX_DATA_W-1:0] data;
    } rx_entry_t;

endpackage

// File: rtl/rx_hold_fifo_mem.sv
// rx_hold_fifo_mem
// Simple dual-port RAM, 2**AWIDTH x WIDTH. Synchronous write, asynchronous
// read at raddr. The array has no reset; its contents only become visible
// through pointers that the top module does reset.
// Ports:
//   clk    in  write clock
//   we     in  write enable
//   waddr  in  write address
//   wdata  in  write data
//   raddr  in  read address
//   rdata  out combinational read data at raddr
module rx_hold_fifo_mem #(
    parameter int AWIDTH = 3,
    parameter int WIDTH  = 72
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AWIDTH-1:0] waddr,
    input  logic [WIDTH-1:0]  wdata,
    input  logic [AWIDTH-1:0] raddr,
    output logic [WIDTH-1:0]  rdata
);

    localparam int DEPTH = 2 ** AWIDTH;

    logic [WIDTH-1:0] mem_arr [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_arr[waddr] <= wdata;
        end
    end

    assign rdata = mem_arr[raddr];

endmodule

// File: rtl/rx_hold_fifo_buf.sv
// rx_hold_fifo_buf
// Receive-side hold buffer between the XGMII RX decoder (writer) and the RX
// enqueue logic (reader). A 2**AWIDTH entry memory feeds a show-ahead output
// register, so total capacity is DEPTH + 1 entries. Writes while the memory
// is full are dropped and counted in a saturating 16-bit counter.
// Ports:
//   clk_xgmii_rx / reset_xgmii_rx   clock, asynchronous active-high reset
//   rxhfifo_wdata/wstatus/wen       write side
//   rxhfifo_wfull/walmost_full      write back-pressure (memory only)
//   rxhfifo_ren                     pop the presented entry
//   rxhfifo_rdata/rstatus/rempty    show-ahead head of queue
//   rxhfifo_ralmost_empty           memory count + output valid <= AE_THRESH
//   rxhfifo_ovf_cnt/ovf_clr         dropped-write counter and its clear
module rx_hold_fifo_buf
    import rx_hold_fifo_buf_pkg::*;
#(
    parameter int AWIDTH    = RX_HOLD_FIFO_AWIDTH,
    parameter int AF_THRESH = 4,
    parameter int AE_THRESH = 7
) (
    input  logic                 clk_xgmii_rx,
    input  logic                 reset_xgmii_rx,
    input  logic [RX_DATA_W-1:0] rxhfifo_wdata,
    input  logic [RX_STAT_W-1:0] rxhfifo_wstatus,
    input  logic                 rxhfifo_wen,
    output logic                 rxhfifo_wfull,
    output logic                 rxhfifo_walmost_full,
    input  logic                 rxhfifo_ren,
    output logic [RX_DATA_W-1:0] rxhfifo_rdata,
    output logic [RX_STAT_W-1:0] rxhfifo_rstatus,
    output logic                 rxhfifo_rempty,
    output logic                 rxhfifo_ralmost_empty,
    output logic [15:0]          rxhfifo_ovf_cnt,
    input  logic                 rxhfifo_ovf_clr
);

    localparam int              DEPTH   = 2 ** AWIDTH;
    localparam logic [AWIDTH:0] DEPTH_V = (AWIDTH + 1)'(DEPTH);

    logic [AWIDTH:0]        wptr_reg;
    logic [AWIDTH:0]        rptr_reg;
    logic                   out_valid_reg;
    logic [RX_DATA_W-1:0]   rdata_reg;
    logic [RX_STAT_W-1:0]   rstatus_reg;
    logic [15:0]            ovf_cnt_reg;

    logic [AWIDTH:0]        mem_cnt;
    logic [AWIDTH:0]        mem_free;
    logic [AWIDTH+1:0]      total_cnt;
    logic                   wr_accept;
    logic                   wr_drop;
    logic                   pop;
    logic                   load_head;
    rx_entry_t              wr_entry;
    rx_entry_t              head_entry;

    // Pointers carry one extra bit so full and empty are distinguishable;
    // the subtraction wraps naturally.
    assign mem_cnt   = wptr_reg - rptr_reg;
    assign mem_free  = DEPTH_V - mem_cnt;
    assign total_cnt = {1'b0, mem_cnt} + {{(AWIDTH + 1){1'b0}}, out_valid_reg};

    assign rxhfifo_wfull         = (mem_cnt == DEPTH_V);
    assign rxhfifo_walmost_full  = (32'(mem_free) <= AF_THRESH);
    assign rxhfifo_ralmost_empty = (32'(total_cnt) <= AE_THRESH);
    assign rxhfifo_rempty        = !out_valid_reg;
    assign rxhfifo_rdata         = rdata_reg;
    assign rxhfifo_rstatus       = rstatus_reg;
    assign rxhfifo_ovf_cnt       = ovf_cnt_reg;

    // Fullness is judged on the pre-edge count, so a pop in the same cycle
    // never frees room for a simultaneous write.
    assign wr_accept = rxhfifo_wen && !rxhfifo_wfull;
    assign wr_drop   = rxhfifo_wen && rxhfifo_wfull;
    assign pop       = rxhfifo_ren && out_valid_reg;
    // The head is taken from memory only if it was already there before this
    // edge; a word written this cycle shows up one edge later.
    assign load_head = (mem_cnt != '0) && (!out_valid_reg || pop);

    assign wr_entry.status = rxhfifo_wstatus;
    assign wr_entry.data   = rxhfifo_wdata;

    rx_hold_fifo_mem #(
        .AWIDTH (AWIDTH),
        .WIDTH  (RX_ENTRY_W)
    ) u_mem (
        .clk   (clk_xgmii_rx),
        .we    (wr_accept),
        .waddr (wptr_reg[AWIDTH-1:0]),
        .wdata (wr_entry),
        .raddr (rptr_reg[AWIDTH-1:0]),
        .rdata (head_entry)
    );

    always_ff @(posedge clk_xgmii_rx or posedge reset_xgmii_rx) begin
        if (reset_xgmii_rx) begin
            wptr_reg      <= '0;
            rptr_reg      <= '0;
            out_valid_reg <= 1'b0;
            rdata_reg     <= '0;
            rstatus_reg   <= '0;
            ovf_cnt_reg   <= '0;
        end else begin
            if (wr_accept) begin
                wptr_reg <= wptr_reg + 1'b1;
            end

            if (load_head) begin
                rptr_reg      <= rptr_reg + 1'b1;
                out_valid_reg <= 1'b1;
                rdata_reg     <= head_entry.data;
                rstatus_reg   <= head_entry.status;
            end else if (pop) begin
                out_valid_reg <= 1'b0;
            end

            // Clear wins over a same-cycle drop.
            if (rxhfifo_ovf_clr) begin
                ovf_cnt_reg <= '0;
            end else if (wr_drop && (ovf_cnt_reg != 16'hFFFF)) begin
                ovf_cnt_reg <= ovf_cnt_reg + 16'd1;
            end
        end
    end

endmodule
